// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges stage stall requests, sequences
// exception/ERET flushes (deferred behind data-bus waits), watchdog and perf counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        exc_valid_i,
  input  logic        exc_eret_i,
  input  logic [31:0] epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        wdog_o,
  output logic        wdog_flag_o,
  output logic [31:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  // state    | meaning
  // RUN      | normal operation; exceptions flush immediately unless MEM is busy
  // EXC_PEND | exception latched, waiting for the data-bus access to finish
  typedef enum logic {RUN = 1'b0, EXC_PEND = 1'b1} state_t;

  localparam int unsigned CW = $clog2(WDOG_LIMIT + 1);
  localparam logic [CW-1:0] LIM    = CW'(WDOG_LIMIT);
  localparam logic [CW-1:0] LIM_M1 = CW'(WDOG_LIMIT - 1);

  state_t        state, state_nxt;
  logic [31:0]   pend_tgt;
  logic [5:0]    req_vec;
  logic [CW-1:0] run_cnt;
  logic          stalled;

  always_comb begin
    req_vec = 6'b000000;
    if (stallreq_mem)     req_vec = 6'b011111;
    else if (stallreq_ex) req_vec = 6'b001111;
    else if (stallreq_id) req_vec = 6'b000111;
    else if (stallreq_if) req_vec = 6'b000011;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (exc_valid_i && stallreq_mem) state_nxt = EXC_PEND;
      EXC_PEND: if (!stallreq_mem)               state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall_o  = req_vec;
    flush_o  = 1'b0;
    new_pc_o = 32'h0;
    case (state)
      RUN: begin
        if (exc_valid_i && !stallreq_mem) begin
          stall_o  = 6'b000000;
          flush_o  = 1'b1;
          new_pc_o = exc_eret_i ? epc_i : EXC_VECTOR;
        end
      end
      EXC_PEND: begin
        if (stallreq_mem) begin
          stall_o = 6'b011111;
        end else begin
          stall_o  = 6'b000000;
          flush_o  = 1'b1;
          new_pc_o = pend_tgt;
        end
      end
      default: ;
    endcase
  end

  // Target is captured once on entry to EXC_PEND and frozen until the flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_tgt <= 32'h0;
    end else if (state == RUN && exc_valid_i && stallreq_mem) begin
      pend_tgt <= exc_eret_i ? epc_i : EXC_VECTOR;
    end
  end

  assign stalled = |stall_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt     <= '0;
      wdog_o      <= 1'b0;
      wdog_flag_o <= 1'b0;
    end else begin
      wdog_o <= stalled && (run_cnt == LIM_M1);
      if (stalled && (run_cnt == LIM_M1)) wdog_flag_o <= 1'b1;
      if (!stalled)           run_cnt <= '0;
      else if (run_cnt != LIM) run_cnt <= run_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= 32'h0;
      flush_cnt_o <= 16'h0;
    end else begin
      if (stalled) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_o) flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end

endmodule
